// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the data-memory requester slice.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 64;
  localparam int unsigned DMEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_ISSUE,
    RSP
  } state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] adr;
    logic [DMEM_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_requester_if.sv
// Request/response handshake bundle between a client and dmem_requester.
interface dmem_requester_if
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_adr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO with a parallel address compare across all valid entries.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_adr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] cmp_adr,
  output logic              hit,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_adr,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] adr_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_adr  = adr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        adr_q[wr_ptr]   <= push_adr;
        data_q[wr_ptr]  <= push_data;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The entry being popped this cycle is still valid here, so it still counts as a hit.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (adr_q[i] == cmp_adr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_requester.sv
// Initiator for the split read/write data memory: posted writes, hazard-checked
// reads and a registered read response.
module dmem_requester
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W     = DMEM_DATA_W,
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_requester_if.slave   bus,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_read_adr,
  output logic [ADDR_W-1:0] mem_write_adr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              idle
);

  state_t            state;
  logic [ADDR_W-1:0] rd_adr;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] wr_adr_hold;
  logic [DATA_W-1:0] wr_data_hold;

  logic              req_ready_w;
  logic              accept;
  logic              push;
  logic              rd_accept;
  logic [ADDR_W-1:0] cmp_adr;
  logic              hit;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] head_adr;
  logic [DATA_W-1:0] head_data;

  assign req_ready_w = rst_n && (state == IDLE) && !full;
  assign accept      = bus.req_valid && req_ready_w;
  assign push        = accept && bus.req_we;
  assign rd_accept   = accept && !bus.req_we;
  assign cmp_adr     = (state == IDLE) ? bus.req_adr : rd_adr;

  dmem_wbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_adr  (bus.req_adr),
    .push_data (bus.req_wdata),
    .pop       (!empty),
    .cmp_adr   (cmp_adr),
    .hit       (hit),
    .full      (full),
    .empty     (empty),
    .head_adr  (head_adr),
    .head_data (head_data)
  );

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Write port shows the head while draining and holds the last drained entry otherwise.
  assign mem_wr        = rst_n && !empty;
  assign mem_write_adr = empty ? wr_adr_hold  : head_adr;
  assign mem_data_in   = empty ? wr_data_hold : head_data;
  assign mem_rd        = mem_rd_q;
  assign mem_read_adr  = rd_adr;
  assign idle          = empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_adr       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      wr_adr_hold  <= '0;
      wr_data_hold <= '0;
    end else begin
      if (!empty) begin
        wr_adr_hold  <= head_adr;
        wr_data_hold <= head_data;
      end
      unique case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_adr   <= bus.req_adr;
            state    <= hit ? RD_WAIT : RD_ISSUE;
            mem_rd_q <= !hit;
          end
        end
        RD_WAIT: begin
          if (!hit) begin
            state    <= RD_ISSUE;
            mem_rd_q <= 1'b1;
          end
        end
        RD_ISSUE: begin
          mem_rd_q    <= 1'b0;
          rsp_rdata_q <= mem_data_out;
          rsp_valid_q <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_requester.sv
// Directed self-checking bench for dmem_requester with a behavioural memory model.
module tb_dmem_requester;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_read_adr;
  logic [AW-1:0] mem_write_adr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_data_out;
  logic          idle;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mem_model [1024];

  dmem_requester_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_requester #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .mem_data_in   (mem_data_in),
    .mem_read_adr  (mem_read_adr),
    .mem_write_adr (mem_write_adr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_data_out  (mem_data_out),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr) mem_model[mem_write_adr] <= mem_data_in;
  assign mem_data_out = (mem_rd && mem_wr && mem_read_adr == mem_write_adr) ? 'x : mem_model[mem_read_adr];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_rd === 1'b1 && mem_wr === 1'b1) begin
      n_checks++;
      if (mem_read_adr === mem_write_adr) $display("FAIL rd_wr_collide: read_adr=%h write_adr=%h required different", mem_read_adr, mem_write_adr);
      else n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_adr   = adr;
    bus.req_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b required 0", mem_rd); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got %b required 0", mem_wr); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== '0) $display("FAIL rst_rsp_rdata: got %h required 0", bus.rsp_rdata); else n_pass++;
    n_checks++; if (mem_read_adr !== '0) $display("FAIL rst_read_adr: got %h required 0", mem_read_adr); else n_pass++;
    n_checks++; if (mem_write_adr !== '0) $display("FAIL rst_write_adr: got %h required 0", mem_write_adr); else n_pass++;
    n_checks++; if (mem_data_in !== '0) $display("FAIL rst_data_in: got %h required 0", mem_data_in); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b required 1", idle); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready_low: got %b required 0", bus.req_ready); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready_high: got %b required 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_writes_then_read();
    drive_req(1'b1, 1'b1, 10'h3FF, 64'hDEADBEEF_00000001);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL wr_ready: got %b required 1", bus.req_ready); else n_pass++;
    tick();
    n_checks++; if (mem_wr !== 1'b1) $display("FAIL wr0_mem_wr: got %b required 1", mem_wr); else n_pass++;
    n_checks++; if (mem_write_adr !== 10'h3FF) $display("FAIL wr0_adr: got %h required 3ff", mem_write_adr); else n_pass++;
    n_checks++; if (mem_data_in !== 64'hDEADBEEF_00000001) $display("FAIL wr0_data: got %h required deadbeef00000001", mem_data_in); else n_pass++;
    drive_req(1'b1, 1'b1, 10'h000, 64'h1);
    tick();
    n_checks++; if (mem_wr !== 1'b1) $display("FAIL wr1_mem_wr: got %b required 1", mem_wr); else n_pass++;
    n_checks++; if (mem_write_adr !== 10'h000) $display("FAIL wr1_adr: got %h required 000", mem_write_adr); else n_pass++;
    n_checks++; if (mem_data_in !== 64'h1) $display("FAIL wr1_data: got %h required 1", mem_data_in); else n_pass++;
    drive_req(1'b1, 1'b0, 10'h3FF, '0);
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    n_checks++; if (mem_rd !== 1'b1) $display("FAIL rd_issue: got %b required 1", mem_rd); else n_pass++;
    n_checks++; if (mem_read_adr !== 10'h3FF) $display("FAIL rd_adr: got %h required 3ff", mem_read_adr); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rd_early_rsp: got %b required 0", bus.rsp_valid); else n_pass++;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b required 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== 64'hDEADBEEF_00000001) $display("FAIL rd_rsp_data: got %h required deadbeef00000001", bus.rsp_rdata); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL rd_one_cycle: got %b required 0", mem_rd); else n_pass++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rd_rsp_drop: got %b required 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rd_back_idle: got %b required 1", idle); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rd_back_ready: got %b required 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_raw_hazard();
    for (int i = 1; i <= 4; i++) begin
      drive_req(1'b1, 1'b1, 10'h005, 64'(i));
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL raw_ready%0d: got %b required 1", i, bus.req_ready); else n_pass++;
      tick();
      n_checks++; if (mem_wr !== 1'b1 || mem_data_in !== 64'(i)) $display("FAIL raw_drain%0d: wr=%b data=%h required wr=1 data=%h", i, mem_wr, mem_data_in, 64'(i)); else n_pass++;
    end
    drive_req(1'b1, 1'b0, 10'h005, '0);
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL raw_wait_rd: got %b required 0", mem_rd); else n_pass++;
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL raw_wait_ready: got %b required 0", bus.req_ready); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL raw_wait_wr: got %b required 0", mem_wr); else n_pass++;
    n_checks++; if (mem_write_adr !== 10'h005) $display("FAIL raw_hold_adr: got %h required 005", mem_write_adr); else n_pass++;
    tick();
    n_checks++; if (mem_rd !== 1'b1 || mem_read_adr !== 10'h005) $display("FAIL raw_issue: rd=%b adr=%h required rd=1 adr=005", mem_rd, mem_read_adr); else n_pass++;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'h4) $display("FAIL raw_rsp: valid=%b data=%h required valid=1 data=4", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL raw_rsp_drop: got %b required 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_disjoint();
    drive_req(1'b1, 1'b1, 10'h020, 64'hC0FFEE00_00001234);
    tick();
    drive_req(1'b1, 1'b1, 10'h010, 64'hA);
    tick();
    drive_req(1'b1, 1'b1, 10'h011, 64'hB);
    tick();
    drive_req(1'b1, 1'b0, 10'h020, '0);
    n_checks++; if (mem_wr !== 1'b1 || mem_write_adr !== 10'h011) $display("FAIL dj_pending: wr=%b adr=%h required wr=1 adr=011", mem_wr, mem_write_adr); else n_pass++;
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    n_checks++; if (mem_rd !== 1'b1 || mem_read_adr !== 10'h020) $display("FAIL dj_issue: rd=%b adr=%h required rd=1 adr=020", mem_rd, mem_read_adr); else n_pass++;
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'hC0FFEE00_00001234) $display("FAIL dj_rsp: valid=%b data=%h required valid=1 data=c0ffee0000001234", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    drive_req(1'b1, 1'b0, 10'h3FF, '0);
    tick();
    drive_req(1'b1, 1'b1, 10'h3FF, 64'hBAD);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'hDEADBEEF_00000001) $display("FAIL bp_hold%0d: valid=%b data=%h required valid=1 data=deadbeef00000001", i, bus.rsp_valid, bus.rsp_rdata); else n_pass++;
      n_checks++; if (bus.req_ready !== 1'b0 || mem_wr !== 1'b0) $display("FAIL bp_block%0d: ready=%b wr=%b required 0 0", i, bus.req_ready, mem_wr); else n_pass++;
      tick();
    end
    drive_req(1'b0, 1'b0, '0, '0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0 || idle !== 1'b1 || bus.req_ready !== 1'b1) $display("FAIL bp_release: valid=%b idle=%b ready=%b required 0 1 1", bus.rsp_valid, idle, bus.req_ready); else n_pass++;
    n_checks++; if (mem_model[10'h3FF] !== 64'hDEADBEEF_00000001) $display("FAIL bp_no_write: mem[3ff]=%h required deadbeef00000001", mem_model[10'h3FF]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 1'b1, 10'h050, 64'h55);
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_wr !== 1'b0 || bus.req_ready !== 1'b0) $display("FAIL rm_wr_in_rst: wr=%b ready=%b required 0 0", mem_wr, bus.req_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    n_checks++; if (idle !== 1'b1 || mem_wr !== 1'b0 || mem_write_adr !== '0) $display("FAIL rm_flushed: idle=%b wr=%b adr=%h required 1 0 000", idle, mem_wr, mem_write_adr); else n_pass++;
    n_checks++; if (mem_model[10'h050] === 64'h55) $display("FAIL rm_discarded: mem[050]=%h required not 55", mem_model[10'h050]); else n_pass++;
    drive_req(1'b1, 1'b1, 10'h060, 64'h66);
    tick();
    drive_req(1'b1, 1'b0, 10'h060, '0);
    tick();
    drive_req(1'b0, 1'b0, '0, '0);
    n_checks++; if (mem_rd !== 1'b0 || bus.req_ready !== 1'b0) $display("FAIL rm_in_wait: rd=%b ready=%b required 0 0", mem_rd, bus.req_ready); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || mem_rd !== 1'b0 || idle !== 1'b1) $display("FAIL rm_wait_rst: valid=%b rd=%b idle=%b required 0 0 1", bus.rsp_valid, mem_rd, idle); else n_pass++;
    tick();
    n_checks++; if (mem_rd !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL rm_no_inflight: rd=%b valid=%b required 0 0", mem_rd, bus.rsp_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_writes_then_read();
    test_raw_hazard();
    test_disjoint();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
